// File: rtl/v2f_seq_divmod.sv
// Sequential restoring divider: one quotient bit per clock, unsigned WIDTH-bit
// quotient and remainder with valid/ready handshakes on input and output.
module v2f_seq_divmod #(
   parameter int WIDTH = 64
) (
   input  logic             CLK,
   input  logic             SRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] N,
   input  logic [WIDTH-1:0] D,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_reg;
   state_t           state_next;

   logic [WIDTH-1:0] dvd_reg;
   logic [WIDTH-1:0] dvs_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [CW-1:0]    count_reg;
   logic             zero_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] r_reg;
   logic             dz_reg;

   logic             accept;
   logic             last_step;
   logic [WIDTH:0]   trial;
   logic             trial_ge;
   logic [WIDTH-1:0] trial_diff;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] dvd_step;

   // The carry-out bit of trial takes part in the compare; once trial >= D the
   // true difference is below D, so the low WIDTH bits of the subtraction suffice.
   always_comb begin
      trial      = {rem_reg, dvd_reg[WIDTH-1]};
      trial_ge   = (trial >= {1'b0, dvs_reg});
      trial_diff = trial[WIDTH-1:0] - dvs_reg;
      rem_step   = trial_ge ? trial_diff : trial[WIDTH-1:0];
      dvd_step   = {dvd_reg[WIDTH-2:0], trial_ge};
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      last_step  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = ~SRST;
            if (in_valid && !SRST) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            // A zero divisor spends a single RUN cycle so its result lands one edge after accept.
            last_step = zero_reg || (count_reg == CW'(1));
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (SRST) begin
         state_reg <= IDLE;
         dvd_reg   <= '0;
         dvs_reg   <= '0;
         rem_reg   <= '0;
         count_reg <= '0;
         zero_reg  <= 1'b0;
         q_reg     <= '0;
         r_reg     <= '0;
         dz_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            dvd_reg   <= N;
            dvs_reg   <= D;
            rem_reg   <= '0;
            count_reg <= CW'(WIDTH);
            zero_reg  <= (D == '0);
         end else if (state_reg == RUN) begin
            if (zero_reg) begin
               q_reg  <= '1;
               r_reg  <= dvd_reg;
               dz_reg <= 1'b1;
            end else begin
               rem_reg   <= rem_step;
               dvd_reg   <= dvd_step;
               count_reg <= count_reg - CW'(1);
               if (last_step) begin
                  q_reg  <= dvd_step;
                  r_reg  <= rem_step;
                  dz_reg <= 1'b0;
               end
            end
         end
      end
   end

   assign Q        = q_reg;
   assign R        = r_reg;
   assign div_zero = dz_reg;

endmodule
